// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: instruction field
// positions, the bubble word and the PC-source encoding.
package fetch_stage_pkg;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int INDEX_MSB  = 25;
    localparam int IMM_MSB    = 15;

    // Instruction word used for pipeline bubbles (sll $0,$0,0)
    localparam logic [31:0] PKG_NOP_WORD = 32'h0000_0000;

    // Where the next PC comes from
    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pc_src_e;

    // PC-relative branch target: pc_plus4 + (sign-extended imm << 2), modulo 2^32
    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [15:0] imm);
        return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC selection: computes branch/jump/jr targets, resolves the branch
// compare and applies the JR > (Jump|JAL) > branch > sequential priority.
module next_pc_sel
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr_index,   // id_instr[25:0]; [15:0] is the branch immediate
    input  logic [31:0] id_pc_plus4,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        Branch_eq,
    input  logic        Branch_ne,
    input  logic        Jump,
    input  logic        JAL,
    input  logic        JR,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    output logic [31:0] next_pc,
    output logic        redirect
);

    pc_src_e pc_src;
    logic    take_br;

    assign take_br = (Branch_eq & (id_rs_val == id_rt_val)) |
                     (Branch_ne & (id_rs_val != id_rt_val));

    // Pick the PC source by priority; control is only meaningful for a valid
    // decode instruction that is not being held by a stall.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        pc_src = PC_SEQ;
        if (JR)
            pc_src = PC_JR;
        else if (Jump | JAL)
            pc_src = PC_JUMP;
        else if (take_br)
            pc_src = PC_BRANCH;
    end

    assign redirect = id_valid & ~stall & (pc_src != PC_SEQ);

    // Target mux; sequential fetch also doubles as the link value source
    always_comb begin
        next_pc = pc + 32'd4;
        if (redirect) begin
            unique case (pc_src)
                PC_JR:     next_pc = id_rs_val;
                PC_JUMP:   next_pc = {id_pc_plus4[31:28], instr_index, 2'b00};
                PC_BRANCH: next_pc = branch_target(id_pc_plus4, instr_index[IMM_MSB:0]);
                default:   next_pc = pc + 32'd4;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request and the
// IF/ID pipeline register with stall hold and flush on redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = PKG_NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        Branch_eq,
    input  logic        Branch_ne,
    input  logic        Jump,
    input  logic        JAL,
    input  logic        JR,
    input  logic [31:0] id_rs_val,
    input  logic [31:0] id_rt_val,
    output logic [31:0] id_instr,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        redirect
);

    logic [31:0] pc;
    logic [31:0] next_pc;

    next_pc_sel u_next_pc_sel (
        .pc          (pc),
        .instr_index (id_instr[INDEX_MSB:0]),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid),
        .stall       (stall),
        .Branch_eq   (Branch_eq),
        .Branch_ne   (Branch_ne),
        .Jump        (Jump),
        .JAL         (JAL),
        .JR          (JR),
        .id_rs_val   (id_rs_val),
        .id_rt_val   (id_rt_val),
        .next_pc     (next_pc),
        .redirect    (redirect)
    );

    assign imem_addr = pc;
    assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
    assign id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];

    // PC and IF/ID update: stall holds, redirect flushes, a fetch fills,
    // a memory miss inserts a bubble. Without a redirect next_pc is PC+4.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            pc          <= RESET_PC;
            id_instr    <= NOP_WORD;
            id_pc_plus4 <= '0;
            id_valid    <= 1'b0;
        end else if (!stall) begin
            if (redirect) begin
                pc          <= next_pc;
                id_instr    <= NOP_WORD;
                id_pc_plus4 <= '0;
                id_valid    <= 1'b0;
            end else if (imem_ready) begin
                pc          <= next_pc;
                id_instr    <= imem_rdata;
                id_pc_plus4 <= next_pc;
                id_valid    <= 1'b1;
            end else begin
                id_instr    <= NOP_WORD;
                id_pc_plus4 <= '0;
                id_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end of the pipelined MIPS core. It produces the instruction word (Opcode/Funct fields) that the decode-stage control unit consumes, and it consumes the control unit's Branch_eq/Branch_ne/JAL/JR outputs plus decode operands to resolve the next PC. It owns the PC register, the instruction-memory request, the IF/ID pipeline register, stall hold and flush-on-redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID for bubbles.

Ports:
clk  in  1  core clock, all state on rising edge.
reset  in  1  asynchronous, active-high; clears all state immediately.
imem_addr  out  32  current PC, driven straight from the PC register.
imem_rdata  in  32  instruction word for imem_addr, valid when imem_ready=1.
imem_ready  in  1  memory returned imem_rdata this cycle.
stall  in  1  hazard unit: hold PC and IF/ID.
Branch_eq  in  1  control unit: decode instruction is beq.
Branch_ne  in  1  control unit: decode instruction is bne.
Jump  in  1  decode instruction is j.
JAL  in  1  control unit: decode instruction is jal.
JR  in  1  control unit: decode instruction is jr.
id_rs_val  in  32  forwarded rs operand in decode.
id_rt_val  in  32  forwarded rt operand in decode.
id_instr  out  32  IF/ID instruction register.
id_opcode  out  6  id_instr[31:26], feeds control unit Opcode.
id_funct  out  6  id_instr[5:0], feeds control unit Funct.
id_pc_plus4  out  32  IF/ID PC+4 register (JAL link value).
id_valid  out  1  IF/ID holds a real instruction.
redirect  out  1  taken branch/jump this cycle (combinational).

Behaviour:
- Reset: PC=RESET_PC, id_instr=NOP_WORD, id_pc_plus4=0, id_valid=0; takes effect asynchronously, including mid-redirect or mid-stall.
- Control inputs are qualified by id_valid; with id_valid=0 redirect=0.
- Targets (32-bit, wrap modulo 2^32): branch = id_pc_plus4 + (sign-extended id_instr[15:0] << 2); jump = {id_pc_plus4[31:28], id_instr[25:0], 2'b00}; jr = id_rs_val.
- Taken: take_br = Branch_eq&(rs==rt) | Branch_ne&(rs!=rt). Priority JR > (Jump|JAL) > take_br > sequential.
- redirect = id_valid & ~stall & (JR | Jump | JAL | take_br).
- Per-cycle next state, evaluated in priority order:
  1. stall=1: PC and IF/ID hold; redirect suppressed, because the branch re-evaluates once stall drops.
  2. redirect=1: PC <= selected target; IF/ID <= {NOP_WORD, 0, valid=0} (flush); imem_ready ignored.
  3. imem_ready=1: PC <= PC+4; id_instr <= imem_rdata; id_pc_plus4 <= PC+4; id_valid <= 1.
  4. imem_ready=0: PC holds; IF/ID <= bubble (valid=0).
- Latency: instruction at PC appears on id_* one cycle after the edge where imem_ready=1. Taken branch costs one bubble. No delay slot.
- PC+4 at 32'hFFFF_FFFC wraps to 0. No alignment check; the low two bits of the target are passed through.
- Decode-stage FSM view (id_valid): EMPTY <-> FULL. A fetch fills it, a redirect or a miss empties it, a stall freezes it.

Decomposition:
- Shared package: OPCODE/FUNCT field positions, NOP_WORD, PC-source encoding (SEQ, BRANCH, JUMP, JR) as constants.
- One sub-module, next_pc_sel: combinational target compute, compare and priority mux, outputting next_pc and redirect. This module holds the registers.

Test Plan:
- Reset mid-run: assert reset asynchronously between edges -> imem_addr=0 and id_valid=0 immediately, before the next clk edge.
- Sequential fetch: imem_ready=1, words 0x20080005, 0x20090003 -> id_instr follows one cycle later, id_pc_plus4=4 then 8, PC=8.
- beq taken: id_instr=0x1109_0002 at id_pc_plus4=0x10, rs=rt=7, Branch_eq=1 -> next PC=0x18, following id_valid=0; same with rs!=rt -> PC=PC+4 and no bubble.
- jal/jr: id_instr=0x0C00_0040, JAL=1 -> PC=0x100. Then JR=1 with JAL=1 and rs=0x44 -> PC=0x44, showing JR priority.
- Stall vs redirect: stall=1 with a taken bne for 2 cycles -> PC and id_* frozen, redirect=0. Stall drops -> redirect taken that cycle.
- Memory wait: imem_ready=0 for 3 cycles -> PC holds, id_valid=0 each cycle, then it resumes. PC=0xFFFF_FFFC with ready -> PC wraps to 0.
